// File: rtl/seg_pkg.sv
// Shared types and constants for seven-segment display monitoring.
// Each font entry is the lit pattern (bits g..a) that displays its index as a hex digit.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [3:0]       nibble_t;

  // Active-low idle: every segment off.
  localparam seg_t SEG_IDLE = 7'h7F;

  localparam seg_t FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_capture_if.sv
// Pin-side bundle of the multiplexed display.
// The master drives the segment and anode pins; the slave snoops them and reports the decoded digits.
interface seg_scan_capture_if;
  import seg_pkg::*;

  logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic an_0, an_1, an_2, an_3, an_4, an_5, an_6, an_7;

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   digit_blank;
  logic                    frame_done;
  logic                    pattern_err;
  logic                    anode_err;

  modport master (
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
    output an_0, an_1, an_2, an_3, an_4, an_5, an_6, an_7,
    input  digits, digit_valid, digit_blank, frame_done, pattern_err, anode_err
  );

  modport slave (
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
    input  an_0, an_1, an_2, an_3, an_4, an_5, an_6, an_7,
    output digits, digit_valid, digit_blank, frame_done, pattern_err, anode_err
  );

endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational lookup of a lit segment pattern against the hex font.
// Flags a font hit, or a fully dark digit.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  seg_t    lit,
  output nibble_t value,
  output logic    hit,
  output logic    blank
);

  always_comb begin
    value = '0;
    hit   = 1'b0;
    blank = (lit == '0);
    for (int i = 0; i < 16; i++) begin
      if (lit == FONT[i]) begin
        value = nibble_t'(i);
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Snoops the multiplexed seven-segment pins and rebuilds the eight displayed hex digits.
// A pin pattern must hold for STABLE_CYCLES edges before it is captured, which rejects changeover ghosting.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_capture_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int SMP_W = NUM_DIGITS + SEG_W;

  logic [SMP_W-1:0] sample_in;
  logic [SMP_W-1:0] sample_q;
  logic [CNT_W-1:0] cnt_q;
  logic             same;
  logic             capture;

  logic [NUM_DIGITS-1:0] an_low;
  logic                  an_one;
  logic                  an_multi;
  logic [2:0]            idx;
  seg_t                  lit;

  nibble_t pat_value;
  logic    pat_hit;
  logic    pat_blank;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_n;
  logic [NUM_DIGITS-1:0]   valid_q, valid_n;
  logic [NUM_DIGITS-1:0]   blank_q, blank_n;
  logic [NUM_DIGITS-1:0]   seen_q, seen_n;
  logic                    frame_done_q, frame_done_n;
  logic                    pattern_err_q, pattern_err_n;
  logic                    anode_err_q, anode_err_n;

  assign sample_in = {bus.an_7, bus.an_6, bus.an_5, bus.an_4,
                      bus.an_3, bus.an_2, bus.an_1, bus.an_0,
                      bus.seg_g, bus.seg_f, bus.seg_e, bus.seg_d,
                      bus.seg_c, bus.seg_b, bus.seg_a};

  assign same    = (sample_in == sample_q);
  // Fires once per dwell: only the edge that takes the count to its saturation value.
  assign capture = same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));

  assign an_low   = ~sample_in[SMP_W-1:SEG_W];
  assign lit      = ~sample_in[SEG_W-1:0];
  assign an_one   = $onehot(an_low);
  assign an_multi = (an_low != '0) && !an_one;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) idx = 3'(i);
    end
  end

  seg_pattern_decode u_decode (
    .lit   (lit),
    .value (pat_value),
    .hit   (pat_hit),
    .blank (pat_blank)
  );

  always_comb begin
    digits_n      = digits_q;
    valid_n       = valid_q;
    blank_n       = blank_q;
    seen_n        = seen_q;
    frame_done_n  = 1'b0;
    pattern_err_n = 1'b0;
    anode_err_n   = 1'b0;
    if (capture) begin
      if (an_multi) begin
        anode_err_n = 1'b1;
      end else if (an_one) begin
        if (pat_hit || pat_blank) begin
          if (pat_hit) begin
            digits_n[{idx, 2'b00} +: 4] = pat_value;
            valid_n[idx]                = 1'b1;
            blank_n[idx]                = 1'b0;
          end else begin
            valid_n[idx] = 1'b0;
            blank_n[idx] = 1'b1;
          end
          seen_n[idx] = 1'b1;
          if (seen_n == '1) begin
            frame_done_n = 1'b1;
            seen_n       = '0;
          end
        end else begin
          pattern_err_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q      <= {{NUM_DIGITS{1'b1}}, SEG_IDLE};
      cnt_q         <= '0;
      digits_q      <= '0;
      valid_q       <= '0;
      blank_q       <= '0;
      seen_q        <= '0;
      frame_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      sample_q <= sample_in;
      if (!same) begin
        cnt_q <= CNT_W'(1);
      end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      digits_q      <= digits_n;
      valid_q       <= valid_n;
      blank_q       <= blank_n;
      seen_q        <= seen_n;
      frame_done_q  <= frame_done_n;
      pattern_err_q <= pattern_err_n;
      anode_err_q   <= anode_err_n;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_blank = blank_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.anode_err   = anode_err_q;

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side monitor for the team's 8-digit multiplexed seven-segment interface. Watches the active-low segment lines and active-low anode lines, and reconstructs the 8 hex digits being displayed.
- Filters ghosting at digit changeover with a stability window.
- Used as a display scoreboard or snooper next to the segment/anode pins: in-system checking and readback of the display driver.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before capture. Legal range 2..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seg_a..seg_g  in  1 each  segment lines, active-low (0 = lit)
- an_0..an_7  in  1 each  anode enables, active-low (0 = digit selected)
- digits  out  32  captured nibbles; digit i in bits [4i+3:4i]
- digit_valid  out  8  bit i = digit i holds a decoded hex value
- digit_blank  out  8  bit i = digit i last captured with all segments off
- frame_done  out  1  one-cycle pulse when all 8 digits captured since last pulse
- pattern_err  out  1  one-cycle pulse: unrecognised segment pattern on a valid anode
- anode_err  out  1  one-cycle pulse: more than one anode low, held stable

Behaviour:
- Reset (rst=1 at a rising edge):
  - digits, digit_valid, digit_blank, seen mask, frame_done, pattern_err and anode_err all become 0.
  - Sample register becomes the idle pattern: all segments 1, all anodes 1.
  - Stability count becomes 0.
  - Reset mid-dwell discards any partial count.
- Sampling:
  - {an_7..an_0, seg_g..seg_a} (15 bits) is compared each edge against the sample register, then registered.
  - Input differs from the register: count <= 1.
  - Input equal: count increments, saturating at STABLE_CYCLES.
- Capture event:
  - Occurs on the edge where count goes STABLE_CYCLES-1 -> STABLE_CYCLES.
  - A pattern held for STABLE_CYCLES consecutive rising edges is therefore visible on the outputs immediately after the STABLE_CYCLES-th edge.
  - Exactly one capture per dwell; further identical samples do nothing.
  - After reset release, a held pattern needs STABLE_CYCLES fresh edges.
- At capture, anode decode:
  - All anodes high: inter-digit blanking. No update, no error.
  - Exactly one anode low (index i): segment decode below.
  - Two or more anodes low: anode_err=1 for one cycle. Nothing else updated.
- Segment decode for index i, with lit = ~{seg_g..seg_a} (bit0 = a):
  - Font table (hex lit pattern gfedcba -> value): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F.
  - Table hit: digits[i] <= value, digit_valid[i] <= 1, digit_blank[i] <= 0, seen[i] <= 1.
  - lit == 00: digit_blank[i] <= 1, digit_valid[i] <= 0, digits[i] unchanged, seen[i] <= 1.
  - Any other pattern: pattern_err=1 for one cycle. digits/valid/blank/seen unchanged.
- Frame tracking:
  - If seen (including this edge's update) == 8'hFF, frame_done=1 on that same edge and seen <= 0.
  - Recapture of an already-seen digit is legal: data overwritten, no extra effect on frame_done.
- Pulse outputs are 0 on every edge with no qualifying event. frame_done and pattern_err can never coincide.
- Outputs hold all captured state indefinitely; there is no timeout.
- Latency from a pattern change to output update is exactly STABLE_CYCLES edges.

Decomposition:
- Package seg_pkg:
  - NUM_DIGITS=8, SEG_W=7, SEG_IDLE=7'h7F (active-low all off)
  - the 16-entry font constant array (lit patterns above)
  - typedef seg_t (logic [6:0]), typedef nibble_t (logic [3:0])
- Sub-module seg_pattern_decode: purely combinational. lit seg_t in; nibble_t value, hit, blank out. Reused by any future segment checker.
- Top holds the sampler, stability counter (width $clog2(STABLE_CYCLES+1)), anode one-hot check and the capture registers.

Test Plan:
- Single digit:
  - Stimulus: STABLE_CYCLES=4; hold an_3=0 (others 1), lit=5B for 4 edges.
  - Response: after 4th edge, digits[15:12]=2, digit_valid=8'h08. No pulses.
  - Holding 10 more edges causes no further change.
- Glitch rejection:
  - Stimulus: an_1=0, lit=07 for 3 edges, then lit=7F for 4 edges.
  - Response: digit 1 = 8. Value 7 never appears. Exactly one capture.
- Full frame:
  - Stimulus: scan digits 0..7 with values 1,2,3,4,5,6,7,8, each held 6 edges, all-anodes-high gap of 2 edges between digits.
  - Response: digits=32'h87654321, digit_valid=8'hFF. frame_done pulses once, on digit 7's capture edge.
  - Second identical scan pulses frame_done again.
- Blank and error:
  - Stimulus: an_5=0 with lit=00, then lit=01, then an_2=an_4=0 held 4 edges.
  - Response: digit_blank[5]=1 and valid[5]=0; then pattern_err pulse; then anode_err pulse. digits unchanged throughout.
- Reset mid-dwell:
  - Stimulus: hold an_0=0, lit=66 for 2 edges, assert rst 1 edge, keep pattern.
  - Response: all outputs 0 after reset. Capture digits[3:0]=4 exactly 4 edges after rst deasserts.
